// File: rtl/periph_pkg.sv
// Address map and TCON bit layout shared by the peripheral bus and its timer.
package periph_pkg;

  localparam logic [31:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [31:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [31:0] ADDR_SWITCH  = 32'h4000_0010;
  localparam logic [31:0] ADDR_DIGI    = 32'h4000_0014;
  localparam logic [31:0] ADDR_SYSTICK = 32'h4000_0018;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;

endpackage

// File: rtl/periph_timer.sv
// Reloading 32-bit timer (TH/TL/TCON) with a level interrupt; CPU writes win over counting,
// except that an overflow in the same cycle still sets the interrupt status.
module periph_timer
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wrTh,
  input  logic        wrTl,
  input  logic        wrTcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irqout
);

  logic        overflow;
  logic        ovfSet;
  logic [31:0] thNext;
  logic [31:0] tlNext;
  logic [2:0]  tconNext;

  always_comb begin
    overflow = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
    ovfSet   = overflow && tcon[TCON_IE];

    thNext = wrTh ? wdata : th;

    // Reload reads the current TH, so a same-cycle TH write only affects the next overflow.
    if (wrTl) begin
      tlNext = wdata;
    end else if (overflow) begin
      tlNext = th;
    end else if (tcon[TCON_EN]) begin
      tlNext = tl + 32'd1;
    end else begin
      tlNext = tl;
    end

    tconNext          = tcon;
    tconNext[TCON_IS] = tcon[TCON_IS] | ovfSet;
    if (wrTcon) begin
      tconNext[TCON_EN] = wdata[TCON_EN];
      tconNext[TCON_IE] = wdata[TCON_IE];
      tconNext[TCON_IS] = wdata[TCON_IS] | ovfSet;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      th   <= thNext;
      tl   <= tlNext;
      tcon <= tconNext;
    end
  end

  assign irqout = tcon[TCON_IE] & tcon[TCON_IS];

endmodule

// File: rtl/peripheral_bus.sv
// Memory-mapped peripherals at 0x4000_00xx: timer, LED, 7-segment, synchronized switches.
// Optional free-running SYSTICK counter at 0x4000_0018 when PERIPH_SYSTICK_EN is defined.
module peripheral_bus
  import periph_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIGI_W      = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic [7:0]        switch,
  output logic [7:0]        led,
  output logic [DIGI_W-1:0] digi,
  output logic              irqout
);

  logic [29:0] wordAddr;
  logic        selTh, selTl, selTcon, selLed, selSwitch, selDigi;
  logic        unusedAddrBits;

  assign wordAddr       = addr[31:2];
  assign unusedAddrBits = ^addr[1:0];

  assign selTh     = (wordAddr == ADDR_TH[31:2]);
  assign selTl     = (wordAddr == ADDR_TL[31:2]);
  assign selTcon   = (wordAddr == ADDR_TCON[31:2]);
  assign selLed    = (wordAddr == ADDR_LED[31:2]);
  assign selSwitch = (wordAddr == ADDR_SWITCH[31:2]);
  assign selDigi   = (wordAddr == ADDR_DIGI[31:2]);

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;

  periph_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .wrTh   (wr & selTh),
    .wrTl   (wr & selTl),
    .wrTcon (wr & selTcon),
    .wdata  (wdata),
    .th     (th),
    .tl     (tl),
    .tcon   (tcon),
    .irqout (irqout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led  <= '0;
      digi <= '0;
    end else begin
      if (wr && selLed)  led  <= wdata[7:0];
      if (wr && selDigi) digi <= wdata[DIGI_W-1:0];
    end
  end

  logic [7:0] syncQ [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) syncQ[i] <= '0;
    end else begin
      syncQ[0] <= switch;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
    end
  end

`ifdef PERIPH_SYSTICK_EN
  logic        selSystick;
  logic [31:0] systick;

  assign selSystick = (wordAddr == ADDR_SYSTICK[31:2]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      systick <= '0;
    end else if (wr && selSystick) begin
      systick <= wdata;
    end else begin
      systick <= systick + 32'd1;
    end
  end
`endif

  // Combinational: the single-cycle core consumes read data in the same cycle.
  always_comb begin
    rdata = '0;
    if (rd) begin
      if (selTh) begin
        rdata = th;
      end else if (selTl) begin
        rdata = tl;
      end else if (selTcon) begin
        rdata = {29'd0, tcon};
      end else if (selLed) begin
        rdata = {24'd0, led};
      end else if (selSwitch) begin
        rdata = {24'd0, syncQ[SYNC_STAGES-1]};
      end else if (selDigi) begin
        rdata[DIGI_W-1:0] = digi;
      end
`ifdef PERIPH_SYSTICK_EN
      else if (selSystick) begin
        rdata = systick;
      end
`endif
    end
  end

endmodule

// File: tb/tb_peripheral_bus.sv
// Randomized bench for peripheral_bus against a behavioural register-map model.
module tb_peripheral_bus;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_DIGI = 32'h4000_0014;
  localparam logic [31:0] A_SYS  = 32'h4000_0018;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  switch;
  logic [7:0]  led;
  logic [11:0] digi;
  logic        irqout;

  always #5 clk = ~clk;

  peripheral_bus dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .rd     (rd),
    .wr     (wr),
    .wdata  (wdata),
    .rdata  (rdata),
    .switch (switch),
    .led    (led),
    .digi   (digi),
    .irqout (irqout)
  );

  // Reference state
  logic [31:0] mTh, mTl, mSys;
  logic        mEn, mIe, mIs;
  logic [7:0]  mLed;
  logic [11:0] mDigi;
  logic [7:0]  swPipe [2];
  logic [7:0]  swNext;

  int nPass   = 0;
  int nChecks = 0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic modelReset();
    mTh = '0; mTl = '0; mSys = '0;
    mEn = 1'b0; mIe = 1'b0; mIs = 1'b0;
    mLed = '0; mDigi = '0;
    swPipe[0] = '0; swPipe[1] = '0;
  endtask

  function automatic logic [31:0] modelRead(input logic r, input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (!r) return 32'd0;
    case (wa)
      A_TH:   return mTh;
      A_TL:   return mTl;
      A_TCON: return {29'd0, mIs, mIe, mEn};
      A_LED:  return {24'd0, mLed};
      A_SW:   return {24'd0, swPipe[1]};
      A_DIGI: return {20'd0, mDigi};
`ifdef PERIPH_SYSTICK_EN
      A_SYS:  return mSys;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelStep(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [7:0] sw);
    logic [31:0] wa;
    logic [31:0] nTl;
    logic [31:0] nSys;
    bit          ovf;
    bit          setIs;
    wa    = {a[31:2], 2'b00};
    ovf   = mEn && (mTl == 32'hFFFF_FFFF);
    setIs = ovf && mIe;
    nTl   = mEn ? (ovf ? mTh : mTl + 32'd1) : mTl;
    nSys  = mSys + 32'd1;
    mIs   = mIs | setIs;
    if (w) begin
      case (wa)
        A_TH:   mTh = d;
        A_TL:   nTl = d;
        A_TCON: begin mEn = d[0]; mIe = d[1]; mIs = d[2] | setIs; end
        A_LED:  mLed = d[7:0];
        A_DIGI: mDigi = d[11:0];
        A_SYS:  nSys = d;
        default: ;
      endcase
    end
    mTl  = nTl;
    mSys = nSys;
    swPipe[1] = swPipe[0];
    swPipe[0] = sw;
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, advance model at posedge.
  task automatic doCycle(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                         input bit hasExp, input logic [31:0] exp, input string tag);
    @(negedge clk);
    rd = r; wr = w; addr = a; wdata = d; switch = swNext;
    #1;
    checkEq({tag, "/rdata"}, rdata, modelRead(r, a));
    if (hasExp) checkEq({tag, "/exp"}, rdata, exp);
    checkEq("led", {24'd0, led}, {24'd0, mLed});
    checkEq("digi", {20'd0, digi}, {20'd0, mDigi});
    checkEq("irqout", {31'd0, irqout}, {31'd0, mIe & mIs});
    @(posedge clk);
    modelStep(w, a, d, switch);
  endtask

  task automatic wrReg(input logic [31:0] a, input logic [31:0] d);
    doCycle(1'b0, 1'b1, a, d, 1'b0, 32'd0, "wr");
  endtask

  task automatic rdReg(input logic [31:0] a, input logic [31:0] exp, input string tag);
    doCycle(1'b1, 1'b0, a, 32'd0, 1'b1, exp, tag);
  endtask

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    switch = '0; swNext = '0;
    modelReset();
    #1;
    checkEq("rst/led", {24'd0, led}, 32'd0);
    checkEq("rst/digi", {20'd0, digi}, 32'd0);
    checkEq("rst/irq", {31'd0, irqout}, 32'd0);
    checkEq("rst/rdata", rdata, 32'd0);
    rd = 1'b1;
    addr = A_TH;   #1 checkEq("rst/th", rdata, 32'd0);
    addr = A_TL;   #1 checkEq("rst/tl", rdata, 32'd0);
    addr = A_TCON; #1 checkEq("rst/tcon", rdata, 32'd0);
    rd = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    modelStep(1'b0, 32'd0, 32'd0, switch);

    // Overflow with reload and interrupt
    wrReg(A_TH, 32'hFFFF_FFFD);
    wrReg(A_TL, 32'hFFFF_FFFE);
    wrReg(A_TCON, 32'd3);
    rdReg(A_TL, 32'hFFFF_FFFE, "ovf/tl0");
    rdReg(A_TL, 32'hFFFF_FFFF, "ovf/tl1");
    #1 checkEq("ovf/irq", {31'd0, irqout}, 32'd1);
    rdReg(A_TL, 32'hFFFF_FFFD, "ovf/reload");
    wrReg(A_TCON, 32'd1);
    #1 checkEq("ovf/irqclr", {31'd0, irqout}, 32'd0);

    // TCON write colliding with overflow keeps the status bit
    wrReg(A_TCON, 32'd0);
    wrReg(A_TL, 32'hFFFF_FFFF);
    wrReg(A_TCON, 32'd3);
    wrReg(A_TCON, 32'd3);
    #1 checkEq("coll/irq", {31'd0, irqout}, 32'd1);
    rdReg(A_TCON, 32'd7, "coll/tcon");
    // TL write wins over reload
    wrReg(A_TL, 32'hFFFF_FFFF);
    wrReg(A_TL, 32'h10);
    rdReg(A_TL, 32'h10, "coll/tl");

    // LED, read-only SWITCH, switch synchronizer
    wrReg(A_LED, 32'hA5);
    #1 checkEq("led/a5", {24'd0, led}, 32'hA5);
    wrReg(A_SW, 32'hFF);
    rdReg(A_SW, 32'd0, "sw/ro");
    swNext = 8'h3C;
    rdReg(A_SW, 32'd0, "sw/lat0");
    rdReg(A_SW, 32'd0, "sw/lat1");
    rdReg(A_SW, 32'h3C, "sw/lat2");
    doCycle(1'b0, 1'b0, A_SW, 32'd0, 1'b1, 32'd0, "sw/nord");

    // SYSTICK slot and unmapped address
    doCycle(1'b1, 1'b0, A_SYS, 32'd0, 1'b0, 32'd0, "sys0");
    doCycle(1'b1, 1'b0, A_SYS, 32'd0, 1'b0, 32'd0, "sys1");
    rdReg(32'h4000_0020, 32'd0, "unmapped");

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int unsigned op;
      int unsigned idx;
      logic [31:0] a;
      logic [31:0] d;
      op  = $urandom_range(0, 9);
      idx = $urandom_range(0, 8);
      a   = 32'h4000_0000 + idx * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) a = 32'h5000_0000 + idx * 4;
      d = $urandom;
      if (idx == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | (d & 32'hF);
      if ($urandom_range(0, 4) == 0) swNext = 8'($urandom);
      if (op < 5)      doCycle(1'b1, 1'b0, a, 32'd0, 1'b0, 32'd0, "rand/rd");
      else if (op < 9) doCycle(1'b0, 1'b1, a, d, 1'b0, 32'd0, "rand/wr");
      else             doCycle(1'b0, 1'b0, a, d, 1'b0, 32'd0, "rand/idle");
    end

    // Asynchronous reset while counting with interrupt pending
    wrReg(A_LED, 32'h5A);
    wrReg(A_DIGI, 32'hFFF);
    wrReg(A_TH, 32'd0);
    wrReg(A_TL, 32'hFFFF_FFFE);
    wrReg(A_TCON, 32'd3);
    doCycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, "pre");
    doCycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, "pre");
    #1 checkEq("prerst/irq", {31'd0, irqout}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkEq("arst/irq", {31'd0, irqout}, 32'd0);
    checkEq("arst/led", {24'd0, led}, 32'd0);
    checkEq("arst/digi", {20'd0, digi}, 32'd0);
    rd = 1'b1;
    addr = A_TL;   #1 checkEq("arst/tl", rdata, 32'd0);
    addr = A_TCON; #1 checkEq("arst/tcon", rdata, 32'd0);
    addr = A_TH;   #1 checkEq("arst/th", rdata, 32'd0);
    rd = 1'b0;
    modelReset();
    swNext = switch;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    modelStep(1'b0, 32'd0, 32'd0, switch);
    for (int n = 0; n < 20; n++) begin
      doCycle(1'b1, 1'b0, 32'h4000_0000 + 32'($urandom_range(0, 6)) * 4, 32'd0, 1'b0, 32'd0,
              "post");
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
